// File: rtl/oka_32bit_seq.sv
// Iterative carry-less 32x32 Karatsuba multiplier sharing one 16x16 carry-less core.
// Latency: product registered 3 edges after accept; one product per 4 cycles max.
// Backpressure: result held in DONE until out_ready; new request accepted same cycle.
module oka_32bit_seq #(
    parameter int N = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [N-1:0]     a,
    input  logic [N-1:0]     b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [2*N-2:0]   y,
    output logic             busy
);

    localparam int H = N / 2;

    typedef enum logic [2:0] {
        IDLE,
        M0,
        M1,
        M2,
        DONE
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic              accept;
    logic [N-1:0]      a_q;
    logic [N-1:0]      b_q;
    logic [2*H-2:0]    z0;
    logic [2*H-2:0]    z1;
    logic [H-1:0]      mul_a;
    logic [H-1:0]      mul_b;
    logic [2*H-2:0]    mul_p;
    logic [2*H-2:0]    mid;
    logic [2*N-2:0]    y_nxt;

    // Handshake: accept from IDLE, or from DONE while the result is consumed.
    always_comb begin
        in_ready = (state == IDLE) || ((state == DONE) && out_ready);
        accept   = in_valid && in_ready;
    end

    // Select the operand halves for the shared core according to the current phase.
    always_comb begin
        mul_a = a_q[H-1:0];
        mul_b = b_q[H-1:0];
        case (state)
            M1: begin
                mul_a = a_q[H-1:0] ^ a_q[N-1:H];
                mul_b = b_q[H-1:0] ^ b_q[N-1:H];
            end
            M2: begin
                mul_a = a_q[N-1:H];
                mul_b = b_q[N-1:H];
            end
            default: begin
                mul_a = a_q[H-1:0];
                mul_b = b_q[H-1:0];
            end
        endcase
    end

    // Shared HxH carry-less multiplier: XOR of shifted partial products.
    always_comb begin
        mul_p = '0;
        for (int i = 0; i < H; i++) begin
            if (mul_b[i]) begin
                mul_p = mul_p ^ ({{(H-1){1'b0}}, mul_a} << i);
            end
        end
    end

    // Karatsuba recombination in M2, where the core output is z2.
    always_comb begin
        mid   = z0 ^ z1 ^ mul_p;
        y_nxt = {{N{1'b0}}, z0}
              ^ ({{N{1'b0}}, mid} << H)
              ^ ({{N{1'b0}}, mul_p} << N);
    end

    // Next-state logic for the phase sequencer.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = M0;
            M0:      state_nxt = M1;
            M1:      state_nxt = M2;
            M2:      state_nxt = DONE;
            DONE: begin
                if (out_ready) begin
                    state_nxt = accept ? M0 : IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State register plus registered status flags derived from the next state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            state     <= state_nxt;
            out_valid <= (state_nxt == DONE);
            busy      <= (state_nxt != IDLE);
        end
    end

    // Datapath: operands load only on accept; sub-products and result load in their phase.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q <= '0;
            b_q <= '0;
            z0  <= '0;
            z1  <= '0;
            y   <= '0;
        end else begin
            if (accept) begin
                a_q <= a;
                b_q <= b;
            end
            if (state == M0) z0 <= mul_p;
            if (state == M1) z1 <= mul_p;
            if (state == M2) y  <= y_nxt;
        end
    end

endmodule

// File: doc/oka_32bit_seq.md
# oka_32bit_seq

Iterative 32×32 carry-less (GF(2)[x]) Karatsuba multiplier controller. It time-shares one combinational 16×16 carry-less multiplier across the three Karatsuba sub-products: z0 = al·bl, z1 = (al⊕ah)·(bl⊕bh), z2 = ah·bh. It then applies the overlap-free recombination to form the 63-bit product. It is the area-reduced, handshaked alternative to the fully parallel 32-bit OKA tree, for use where throughput of one product per 4 cycles is sufficient.

## Interface
- N, 32, operand width; even, ≥4; H = N/2 is the shared sub-multiplier width; product width 2N-1.
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  request strobe; a/b qualified by it.
- in_ready  output  1  controller can accept a request this cycle.
- a  input  N  operand A (polynomial, bit i = coeff of x^i).
- b  input  N  operand B.
- out_valid  output  1  y holds a completed product.
- out_ready  input  1  consumer accepts y this cycle.
- y  output  2N-1  carry-less product a·b.
- busy  output  1  high in any state except IDLE.

## Operation
- FSM states: IDLE, M0, M1, M2, DONE. Reset → IDLE.
- Accept = in_valid & in_ready. On accept, register a, b; split al=a[H-1:0], ah=a[N-1:H] (same for b); go to M0.
- M0: shared multiplier inputs = (al, bl); register z0 (2H-1 bits); → M1.
- M1: inputs = (al⊕ah, bl⊕bh); register z1; → M2.
- M2: inputs = (ah, bh); the product is z2. Register y = z0 ⊕ ((z0⊕z1⊕z2) << H) ⊕ (z2 << N), all XOR, truncated to 2N-1 bits; → DONE.
- DONE: out_valid=1; y stable until out_ready.
  - out_ready=1 with accept the same cycle → M0 with the new operands (back-to-back).
  - out_ready=1 without accept → IDLE.
  - out_ready=0 → stay in DONE.
- in_ready = (state==IDLE) | (state==DONE & out_ready). No request is accepted in M0–M2; a and b are ignored there.
- Shared multiplier: purely combinational carry-less 16×16 (H×H). The result is XOR of shifted partial products; no integer carries anywhere in the block.
- Operand registers are loaded only on accept. They are stable from M0 through DONE.

## Timing
- Reset values: out_valid=0, y=0, busy=0, state IDLE. in_ready=1 while rst is deasserted in IDLE. z0/z1 and operand registers = 0.
- Latency: accept at edge E. out_valid=1 and y valid after edge E+3. Minimum initiation interval is 4 cycles, including back-to-back from DONE.
- out_valid, once high, stays high with y unchanged until a cycle with out_ready=1.
- out_ready is don't-care outside DONE.
- in_valid deasserting in M0–M2 has no effect on the in-flight computation.
- rst asserted in any state, including mid-M1 or DONE with out_valid high: immediate return to reset values. The in-flight request is discarded; no out_valid is produced for it.
- in_ready is combinational from state and out_ready. out_valid, y and busy are registered.

## Test plan
- Basic: reset, then a=0x00000003, b=0x00000003 → y=0x5 exactly 3 edges after accept; busy high M0–DONE; in_ready=0 in M0–M2.
- Middle-term coverage: a=0x00010001, b=0x00010001 → y=0x1_0000_0001. a=0xFFFFFFFF, b=0xFFFFFFFF → y=0x5555_5555_5555_5555.
- MSB boundary: a=0x80000000, b=0x80000000 → y=0x4000_0000_0000_0000. a=0, b=0xDEADBEEF → y=0.
- Backpressure: hold out_ready=0 for 5 cycles in DONE. Required: y and out_valid stable, in_ready=0, a new in_valid ignored. Then out_ready=1 with in_valid=1 (a=1, b=0x12345678) → same-edge accept, next y=0x12345678 after 4 more edges.
- Reset mid-operation: assert rst during M1. Required: out_valid=0, y=0, IDLE. After release, a new request (a=0x2, b=0x3 → y=0x6) completes normally with no stale result.
- Random: 1000 random a/b with random in_valid/out_ready. Each y matches a software carry-less reference; results are in order with no drops or duplicates.
